branch_resolve: RTL and testbench

//  EX-stage branch resolution unit: the producer side of the pc_reg redirect/BTB-update interface.

---
 rtl/branch_resolve.sv | 182 ++++++++++++++++++
 tb/tb_branch_resolve.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve
//   EX-stage branch resolution unit. It evaluates conditional branches, JAL
//   and JALR, compares the actual next PC with the IF-stage prediction and,
//   on a mismatch, sends a registered one-cycle redirect pulse to pc_reg.
//   The pulse is followed by FLUSH_CYCLES further cycles of flush_out, which
//   kill the wrong-path instructions in the front end.
//   Two saturating counters record resolved branches and mispredicts.
// Ports
//   clk_in, rst_in          clock (rising edge), async active-low reset
//   rdy_in                  global ready; 0 freezes all state and outputs
//   stall[5:0]              stall[STALL_IDX]=1 blocks accepting a branch
//   valid_in, br_op_in      branch present / operation (0fff cond, 1000 JAL, 1001 JALR)
//   pc_in, rs1_in, rs2_in   instruction PC and operand values
//   imm_in                  sign-extended offset
//   pre_taken_in/_target_in IF-stage prediction
//   branch_*_out, is_jalr_out  registered redirect / BTB-update information
//   flush_out               front-end kill
//   br_cnt_out, miss_cnt_out   saturating performance counters
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32,
  parameter int STALL_IDX    = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [5:0]       stall,
  input  logic             valid_in,
  input  logic [3:0]       br_op_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      rs1_in,
  input  logic [31:0]      rs2_in,
  input  logic [31:0]      imm_in,
  input  logic             pre_taken_in,
  input  logic [31:0]      pre_target_in,
  output logic             branch_flag_out,
  output logic [31:0]      branch_target_addr_out,
  output logic [31:0]      branch_pc_out,
  output logic             branch_taken_out,
  output logic             is_jalr_out,
  output logic             flush_out,
  output logic [CNT_W-1:0] br_cnt_out,
  output logic [CNT_W-1:0] miss_cnt_out
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FC_W-1:0]   r_flush_cnt;
  logic [FC_W-1:0]   w_flush_cnt_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_imm;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_target;
  logic        w_taken;
  logic        w_is_jalr;
  logic [31:0] w_actual_next;
  logic [31:0] w_pred_next;
  logic        w_mispredict;
  logic        w_accept;
  logic        w_stall_unused;

  // Only one stall bit matters to EX; the rest are folded here on purpose.
  assign w_stall_unused = ^stall;

  assign w_pc_plus4    = pc_in + 32'd4;
  assign w_pc_imm      = pc_in + imm_in;
  assign w_jalr_tgt    = (rs1_in + imm_in) & ~32'h0000_0001;
  assign w_is_jalr     = (br_op_in == 4'b1001);
  assign w_actual_next = w_taken ? w_target : w_pc_plus4;
  assign w_pred_next   = pre_taken_in ? pre_target_in : w_pc_plus4;
  assign w_mispredict  = (w_actual_next != w_pred_next);
  // Wrong-path instructions arriving during REDIRECT/FLUSH are never accepted.
  assign w_accept      = valid_in & rdy_in & ~stall[STALL_IDX] & (r_state == ST_IDLE);

  // Branch direction and taken-target decode.
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc_imm;
    case (br_op_in)
      4'b0000: w_taken = (rs1_in == rs2_in);
      4'b0001: w_taken = (rs1_in != rs2_in);
      4'b0100: w_taken = ($signed(rs1_in) <  $signed(rs2_in));
      4'b0101: w_taken = ($signed(rs1_in) >= $signed(rs2_in));
      4'b0110: w_taken = (rs1_in <  rs2_in);
      4'b0111: w_taken = (rs1_in >= rs2_in);
      4'b1000: w_taken = 1'b1;
      4'b1001: begin
        w_taken  = 1'b1;
        w_target = w_jalr_tgt;
      end
      default: w_taken = 1'b0;
    endcase
  end

  // Redirect/flush sequencing: next state and flush countdown.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_mispredict) begin
            w_state_nxt = ST_REDIRECT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
        end
        ST_FLUSH: begin
          if (r_flush_cnt <= FC_W'(1)) begin
            w_state_nxt     = ST_IDLE;
            w_flush_cnt_nxt = {FC_W{1'b0}};
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_flush_cnt_nxt = {FC_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= {FC_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Registered redirect outputs and saturating performance counters.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      branch_flag_out        <= 1'b0;
      flush_out              <= 1'b0;
      branch_target_addr_out <= 32'd0;
      branch_pc_out          <= 32'd0;
      branch_taken_out       <= 1'b0;
      is_jalr_out            <= 1'b0;
      br_cnt_out             <= {CNT_W{1'b0}};
      miss_cnt_out           <= {CNT_W{1'b0}};
    end else if (rdy_in) begin
      branch_flag_out <= w_accept & w_mispredict;
      flush_out       <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        branch_target_addr_out <= w_actual_next;
        branch_pc_out          <= pc_in;
        branch_taken_out       <= w_taken;
        is_jalr_out            <= w_is_jalr;
        if (br_cnt_out != CNT_MAX) begin
          br_cnt_out <= br_cnt_out + CNT_ONE;
        end
        if (w_mispredict && (miss_cnt_out != CNT_MAX)) begin
          miss_cnt_out <= miss_cnt_out + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus a randomized
// stream, checked through a scoreboard fed by a behavioural reference model.
module tb_branch_resolve;

  localparam int FC = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall;
  logic        valid_in;
  logic [3:0]  br_op_in;
  logic [31:0] pc_in, rs1_in, rs2_in, imm_in, pre_target_in;
  logic        pre_taken_in;

  logic        flag, taken, jalr, flush;
  logic [31:0] target, bpc, br_cnt, miss_cnt;
  logic        flag_s, taken_s, jalr_s, flush_s;
  logic [31:0] target_s, bpc_s;
  logic [3:0]  br_cnt_s, miss_cnt_s;

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(32), .STALL_IDX(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
    .valid_in(valid_in), .br_op_in(br_op_in), .pc_in(pc_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .pre_taken_in(pre_taken_in), .pre_target_in(pre_target_in),
    .branch_flag_out(flag), .branch_target_addr_out(target),
    .branch_pc_out(bpc), .branch_taken_out(taken), .is_jalr_out(jalr),
    .flush_out(flush), .br_cnt_out(br_cnt), .miss_cnt_out(miss_cnt)
  );

  // Narrow-counter instance on the same stimulus, to observe saturation.
  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(4), .STALL_IDX(3)) dut_sat (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
    .valid_in(valid_in), .br_op_in(br_op_in), .pc_in(pc_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .pre_taken_in(pre_taken_in), .pre_target_in(pre_target_in),
    .branch_flag_out(flag_s), .branch_target_addr_out(target_s),
    .branch_pc_out(bpc_s), .branch_taken_out(taken_s), .is_jalr_out(jalr_s),
    .flush_out(flush_s), .br_cnt_out(br_cnt_s), .miss_cnt_out(miss_cnt_s)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        tk;
    logic        jalr;
    int unsigned br;
    int unsigned miss;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned m_br = 0, m_miss = 0;
  int          busy = 0;
  logic        exp_flag = 1'b0, exp_flush = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: resolve one branch straight from the ISA rules.
  function automatic void ref_resolve(input logic [3:0] op, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] imm, input logic pt,
                                      input logic [31:0] ptgt, output logic [31:0] nxt,
                                      output logic tk, output logic miss);
    logic [31:0] seq;
    logic [31:0] tgt;
    seq = pc + 32'd4;
    tgt = pc + imm;
    tk  = 1'b0;
    if (op == 4'd8) tk = 1'b1;
    else if (op == 4'd9) begin
      tk  = 1'b1;
      tgt = (a + imm) & 32'hFFFF_FFFE;
    end else if (op < 4'd8) begin
      case (op)
        4'd0: tk = (a == b);
        4'd1: tk = (a != b);
        4'd4: tk = (int'(a) <  int'(b));
        4'd5: tk = (int'(a) >= int'(b));
        4'd6: tk = (a <  b);
        4'd7: tk = (a >= b);
        default: tk = 1'b0;
      endcase
    end
    nxt  = tk ? tgt : seq;
    miss = (nxt != (pt ? ptgt : seq));
  endfunction

  // Reference model: decides accepts and the busy window after a mispredict.
  initial forever begin
    @(posedge clk_in);
    if (!rst_in) begin
      busy = 0; m_br = 0; m_miss = 0; exp_flag = 1'b0; exp_flush = 1'b0;
      sb_q.delete();
    end else if (rdy_in) begin
      if (busy > 0) begin
        busy--;
        exp_flag = 1'b0;
      end else if (valid_in && !stall[3]) begin
        exp_t e;
        logic [31:0] nxt;
        logic tk, ms;
        ref_resolve(br_op_in, pc_in, rs1_in, rs2_in, imm_in, pre_taken_in, pre_target_in, nxt, tk, ms);
        m_br++;
        if (ms) begin
          m_miss++;
          busy = 1 + FC;
        end
        exp_flag = ms;
        e.tgt = nxt; e.pc = pc_in; e.tk = tk; e.jalr = (br_op_in == 4'd9);
        e.br = m_br; e.miss = m_miss;
        sb_q.push_back(e);
      end else begin
        exp_flag = 1'b0;
      end
      exp_flush = (busy > 0);
    end
  end

  // Monitor: per-cycle flag/flush, and a scoreboard pop whenever a branch resolves.
  initial begin
    logic [31:0] prev_br;
    exp_t e;
    prev_br = 32'd0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in) begin
        prev_br = 32'd0;
      end else begin
        chk("flag", {31'd0, flag}, {31'd0, exp_flag});
        chk("flush", {31'd0, flush}, {31'd0, exp_flush});
        if (br_cnt != prev_br) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_resolve", br_cnt, prev_br);
          end else begin
            e = sb_q.pop_front();
            chk("target", target, e.tgt);
            chk("branch_pc", bpc, e.pc);
            chk("taken", {31'd0, taken}, {31'd0, e.tk});
            chk("is_jalr", {31'd0, jalr}, {31'd0, e.jalr});
            chk("br_cnt", br_cnt, e.br);
            chk("miss_cnt", miss_cnt, e.miss);
            chk("br_cnt_sat", {28'd0, br_cnt_s}, (e.br > 15) ? 32'd15 : e.br);
            chk("miss_cnt_sat", {28'd0, miss_cnt_s}, (e.miss > 15) ? 32'd15 : e.miss);
          end
        end
        prev_br = br_cnt;
      end
    end
  end

  task automatic set_br(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic pt,
                        input logic [31:0] ptgt);
    valid_in = 1'b1; br_op_in = op; pc_in = pc; rs1_in = a; rs2_in = b;
    imm_in = imm; pre_taken_in = pt; pre_target_in = ptgt;
  endtask

  // One-cycle issue; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptgt);
    @(negedge clk_in);
    set_br(op, pc, a, b, imm, pt, ptgt);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    logic [31:0] br0;
    logic [3:0]  ops [10];
    logic [31:0] nxt;
    logic        tk, ms;
    ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd12};
    rst_in = 1'b0; rdy_in = 1'b1; stall = 6'd0; valid_in = 1'b0; br_op_in = 4'd0;
    pc_in = 32'd0; rs1_in = 32'd0; rs2_in = 32'd0; imm_in = 32'd0;
    pre_taken_in = 1'b0; pre_target_in = 32'd0;
    #12;
    chk("reset_flag", {31'd0, flag}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_target", target, 32'd0);
    chk("reset_br_cnt", br_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // BEQ taken, predicted not-taken: redirect to 0x120, flush for 3 cycles.
    issue(4'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'd0);
    chk("t1_flag", {31'd0, flag}, 32'd1);
    chk("t1_target", target, 32'h120);
    chk("t1_pc", bpc, 32'h100);
    chk("t1_taken", {31'd0, taken}, 32'd1);
    chk("t1_counts", {br_cnt[15:0], miss_cnt[15:0]}, {16'd1, 16'd1});
    idle(2);
    chk("t1_flush_held", {31'd0, flush}, 32'd1);
    idle(1);
    chk("t1_flush_done", {31'd0, flush}, 32'd0);

    // BNE not taken, predicted not-taken: no redirect.
    issue(4'd1, 32'h200, 32'd7, 32'd7, 32'h40, 1'b0, 32'd0);
    chk("t2_flag", {31'd0, flag}, 32'd0);
    chk("t2_target", target, 32'h204);
    chk("t2_counts", {br_cnt[15:0], miss_cnt[15:0]}, {16'd2, 16'd1});

    // Signed versus unsigned compare of the same operands.
    issue(4'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310);
    chk("t3_blt_taken", {31'd0, taken}, 32'd1);
    chk("t3_blt_flag", {31'd0, flag}, 32'd0);
    issue(4'd6, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310);
    chk("t3_bltu_taken", {31'd0, taken}, 32'd0);
    chk("t3_bltu_flag", {31'd0, flag}, 32'd1);
    chk("t3_bltu_target", target, 32'h304);
    idle(4);

    // JALR: bit 0 of the computed target is cleared.
    issue(4'd9, 32'h400, 32'h1003, 32'd0, 32'd4, 1'b1, 32'h1006);
    chk("t4_jalr_ok_flag", {31'd0, flag}, 32'd0);
    issue(4'd9, 32'h400, 32'h1003, 32'd0, 32'd4, 1'b1, 32'h1000);
    chk("t4_jalr_flag", {31'd0, flag}, 32'd1);
    chk("t4_jalr_is", {31'd0, jalr}, 32'd1);
    chk("t4_jalr_target", target, 32'h1006);
    idle(4);

    // Wrong-path valid_in during REDIRECT/FLUSH is squashed.
    br0 = br_cnt;
    @(negedge clk_in);
    set_br(4'd0, 32'h500, 32'd1, 32'd1, 32'h8, 1'b0, 32'd0);
    for (int i = 0; i < 1 + FC; i++) begin
      @(negedge clk_in);
      pc_in = pc_in + 32'd4;
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    chk("t5_squash", br_cnt, br0 + 32'd1);

    // EX stall blocks accept until released.
    @(negedge clk_in);
    stall = 6'b001000;
    set_br(4'd8, 32'h600, 32'd0, 32'd0, 32'h100, 1'b1, 32'h700);
    idle(3);
    chk("t5_stall_hold", br_cnt, br0 + 32'd1);
    stall = 6'd0;
    @(negedge clk_in);
    valid_in = 1'b0;
    chk("t5_stall_release", br_cnt, br0 + 32'd2);

    // Asynchronous reset in the middle of a flush.
    issue(4'd0, 32'h800, 32'd3, 32'd3, 32'h40, 1'b0, 32'd0);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("t5_rst_flag", {31'd0, flag}, 32'd0);
    chk("t5_rst_flush", {31'd0, flush}, 32'd0);
    chk("t5_rst_target", target, 32'd0);
    chk("t5_rst_br", br_cnt, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Randomized stream including rdy_in drops and stalls.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      rdy_in   = ($urandom_range(0, 9) != 0);
      stall    = 6'($urandom());
      stall[3] = ($urandom_range(0, 4) == 0);
      valid_in = ($urandom_range(0, 9) < 7);
      br_op_in = ops[$urandom_range(0, 9)];
      pc_in    = {$urandom()} & 32'hFFFF_FFFC;
      rs1_in   = $urandom();
      rs2_in   = ($urandom_range(0, 2) == 0) ? rs1_in : $urandom();
      imm_in   = 32'($signed($urandom_range(0, 4095)) - 2048);
      ref_resolve(br_op_in, pc_in, rs1_in, rs2_in, imm_in, 1'b0, 32'd0, nxt, tk, ms);
      pre_taken_in  = $urandom_range(0, 1);
      pre_target_in = ($urandom_range(0, 1) == 1) ? nxt : $urandom();
    end
    @(negedge clk_in);
    valid_in = 1'b0; rdy_in = 1'b1; stall = 6'd0;
    idle(6);

    // Saturation of the 4-bit counters after 20 mispredicts.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      issue(4'd0, 32'h1000 + 32'(i * 16), 32'd9, 32'd9, 32'h80, 1'b0, 32'd0);
      idle(3);
    end
    chk("t6_sat_br", {28'd0, br_cnt_s}, 32'hF);
    chk("t6_sat_miss", {28'd0, miss_cnt_s}, 32'hF);
    chk("t6_wide_br", br_cnt, 32'd20);
    chk("t6_wide_miss", miss_cnt, 32'd20);

    idle(2);
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
